// File: rtl/button_rotator_pkg.sv
// Shared types and parameter derivations for the button_rotator slice.
package button_rotator_pkg;

  localparam int PATTERN_W = 8;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_LOAD
  } cmd_e;

  function automatic int db_cycles(input int clk_freq, input int debounce_ms);
    return (clk_freq / 1000) * debounce_ms;
  endfunction

  function automatic int repeat_delay(input int clk_freq);
    return clk_freq / 2;
  endfunction

  function automatic int repeat_period(input int clk_freq);
    return clk_freq / 4;
  endfunction

endpackage

// File: rtl/button_rotator_debounce_cell.sv
// One active-low button: 2-FF synchronizer, stability counter, debounced state
// and a one-cycle press pulse on the debounced 1->0 transition.
// Exposes the debounced held state when BUTTON_ROTATOR_AUTO_REPEAT_EN is defined.
module debounce_cell #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
`ifdef BUTTON_ROTATOR_AUTO_REPEAT_EN
  output logic held,
`endif
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1, sync2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       warm;
  logic             armed;

  // A press is only honoured once a released level has been seen after reset,
  // so a button held through reset release needs a fresh press to pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      warm     <= '0;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      warm     <= {warm[0], 1'b1};
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (warm[1] && sync2 && stable) armed <= 1'b1;
      press <= armed & stable_d & ~stable;
    end
  end

`ifdef BUTTON_ROTATOR_AUTO_REPEAT_EN
  assign held = ~stable;
`endif

endmodule

// File: rtl/button_rotator.sv
// Debounced left/right/load buttons driving an 8-bit rotating LED pattern.
// Optional hold-to-repeat for left/right: define BUTTON_ROTATOR_AUTO_REPEAT_EN.
module button_rotator
  import button_rotator_pkg::*;
#(
  parameter int             CLK_FREQ     = 25_000_000,
  parameter int             DEBOUNCE_MS  = 10,
  parameter logic [7:0]     INIT_PATTERN = 8'h1F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_left_n,
  input  logic                 btn_right_n,
  input  logic                 btn_load_n,
  input  logic [PATTERN_W-1:0] sw,
  output logic [PATTERN_W-1:0] pattern,
  output logic                 press_left,
  output logic                 press_right,
  output logic                 press_load
);

  localparam int DB_CYCLES = db_cycles(CLK_FREQ, DEBOUNCE_MS);

  logic                 db_left, db_right;
  logic [PATTERN_W-1:0] sw_sync1, sw_sync2;
  cmd_e                 cmd;

`ifdef BUTTON_ROTATOR_AUTO_REPEAT_EN
  logic held_left, held_right, held_load;

  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_left_n), .held(held_left), .press(db_left));
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_right_n), .held(held_right), .press(db_right));
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_load_n), .held(held_load), .press(press_load));

  localparam int REPEAT_DELAY  = repeat_delay(CLK_FREQ);
  localparam int REPEAT_PERIOD = repeat_period(CLK_FREQ);
  localparam int RW            = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    held, db_press, rep, active, first;
  logic [RW-1:0] rcnt [2];

  assign held     = {held_right, held_left};
  assign db_press = {db_right, db_left};

  // rcnt counts cycles since the last emitted pulse (initial or repeat);
  // the first gap uses REPEAT_DELAY, later gaps REPEAT_PERIOD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep    <= '0;
      active <= '0;
      first  <= '0;
      for (int unsigned i = 0; i < 2; i++) rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (!held[i]) begin
          rep[i]    <= 1'b0;
          active[i] <= 1'b0;
          first[i]  <= 1'b0;
          rcnt[i]   <= '0;
        end else begin
          rep[i] <= active[i] && (rcnt[i] == (first[i] ? DELAY_LAST : PERIOD_LAST));
          if (db_press[i] || rep[i]) begin
            rcnt[i]   <= RW'(1);
            active[i] <= 1'b1;
            first[i]  <= db_press[i];
          end else if (active[i]) begin
            rcnt[i] <= rcnt[i] + RW'(1);
          end
        end
      end
    end
  end

  assign press_left  = db_left  | rep[0];
  assign press_right = db_right | rep[1];
`else
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_left_n), .press(db_left));
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_right_n), .press(db_right));
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_load_n), .press(press_load));

  assign press_left  = db_left;
  assign press_right = db_right;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= sw;
      sw_sync2 <= sw_sync1;
    end
  end

  // Load wins over rotation; simultaneous left+right cancel out.
  always_comb begin
    cmd = CMD_NONE;
    if (press_load)                      cmd = CMD_LOAD;
    else if (press_left && !press_right) cmd = CMD_LEFT;
    else if (press_right && !press_left) cmd = CMD_RIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= INIT_PATTERN;
    end else begin
      unique case (cmd)
        CMD_LOAD:  pattern <= sw_sync2;
        CMD_LEFT:  pattern <= {pattern[PATTERN_W-2:0], pattern[PATTERN_W-1]};
        CMD_RIGHT: pattern <= {pattern[0], pattern[PATTERN_W-1:1]};
        default:   pattern <= pattern;
      endcase
    end
  end

endmodule

// File: tb/tb_button_rotator.sv
// Directed bench for button_rotator with CLK_FREQ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4).
module tb_button_rotator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_left_n, btn_right_n, btn_load_n;
  logic [7:0] sw;
  logic [7:0] pattern;
  logic       press_left, press_right, press_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_rotator #(
    .CLK_FREQ(1000),
    .DEBOUNCE_MS(4),
    .INIT_PATTERN(8'h1F)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_left_n(btn_left_n),
    .btn_right_n(btn_right_n),
    .btn_load_n(btn_load_n),
    .sw(sw),
    .pattern(pattern),
    .press_left(press_left),
    .press_right(press_right),
    .press_load(press_load)
  );

  typedef struct {
    logic       l, r, ld;
    logic [7:0] swv;
    logic [7:0] exp_pat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_check(input int n, input string name);
    int pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (press_left || press_right || press_load) pulses++;
    end
    check(name, pulses, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Drive a press on the chosen buttons, expect a pulse 7 cycles later, then release.
  task automatic press(input logic l, input logic r, input logic ld,
                       input logic [7:0] swv, input logic [7:0] exp_pat, input string name);
    int         lat = 0;
    logic [2:0] seen = 3'b000;
    sw = swv;
    repeat (3) @(negedge clk);
    btn_left_n  = ~l;
    btn_right_n = ~r;
    btn_load_n  = ~ld;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (press_left || press_right || press_load) begin
        lat  = k;
        seen = {press_left, press_right, press_load};
      end
    end
    check({name, " latency"}, lat, 7);
    check({name, " pulses"}, seen, {l, r, ld});
    @(negedge clk);
    check({name, " one-cycle"}, {press_left, press_right, press_load}, 3'b000);
    check({name, " pattern"}, pattern, exp_pat);
    idle_check(15, {name, " hold no repeat"});
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    btn_load_n  = 1'b1;
    idle_check(15, {name, " release no pulse"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;

    vecs[0]  = '{1, 1, 0, 8'h00, 8'h1F};
    vecs[1]  = '{0, 0, 1, 8'h81, 8'h81};
    vecs[2]  = '{1, 0, 0, 8'h00, 8'h03};
    vecs[3]  = '{0, 1, 0, 8'h00, 8'h81};
    vecs[4]  = '{0, 1, 0, 8'h00, 8'hC0};
    vecs[5]  = '{1, 1, 0, 8'h00, 8'hC0};
    vecs[6]  = '{1, 0, 0, 8'h00, 8'h81};
    vecs[7]  = '{0, 0, 1, 8'h00, 8'h00};
    vecs[8]  = '{1, 0, 0, 8'h00, 8'h00};
    vecs[9]  = '{0, 1, 0, 8'h00, 8'h00};
    vecs[10] = '{0, 0, 1, 8'hFF, 8'hFF};
    vecs[11] = '{1, 0, 0, 8'h00, 8'hFF};
    vecs[12] = '{0, 1, 0, 8'h00, 8'hFF};

    rst_n = 1'b0;
    btn_left_n = 1'b1; btn_right_n = 1'b1; btn_load_n = 1'b1;
    sw = 8'h00;
    repeat (3) @(negedge clk);
    check("reset pattern", pattern, 8'h1F);
    check("reset pulses", {press_left, press_right, press_load}, 3'b000);
    rst_n = 1'b1;
    idle_check(20, "idle after reset");
    check("idle pattern", pattern, 8'h1F);

    press(1, 0, 0, 8'h00, 8'h3E, "left_clean");

    do_reset();
    for (int i = 0; i < 13; i++)
      press(vecs[i].l, vecs[i].r, vecs[i].ld, vecs[i].swv, vecs[i].exp_pat,
            $sformatf("vec%0d", i));

    // Bounce on right: 2-cycle glitches never reach the 4-cycle window.
    do_reset();
    begin
      int pulses = 0;
      for (int k = 0; k < 20; k++) begin
        btn_right_n = k[1];
        @(negedge clk);
        if (press_left || press_right || press_load) pulses++;
      end
      check("bounce no pulse", pulses, 0);
    end
    btn_right_n = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (press_right) lat = k;
    end
    check("bounce settle latency", lat, 7);
    @(negedge clk);
    check("bounce pattern", pattern, 8'h8F);
    btn_right_n = 1'b1;
    idle_check(15, "bounce release");

    // Reset while left has been low for 2 cycles, then keep it held.
    btn_left_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset pattern", pattern, 8'h1F);
    check("midreset pulses", {press_left, press_right, press_load}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check(30, "held through reset");
    check("held through reset pattern", pattern, 8'h1F);
    btn_left_n = 1'b1;
    idle_check(15, "held release");
    press(1, 0, 0, 8'h00, 8'h3E, "left_after_rearm");

`ifdef BUTTON_ROTATOR_AUTO_REPEAT_EN
    do_reset();
    begin
      int times [4];
      int n = 0;
      btn_left_n = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
        @(negedge clk);
        if (press_left) begin
          if (n < 4) times[n] = k;
          n++;
        end
      end
      check("repeat count", n, 3);
      check("repeat first", times[0], 7);
      check("repeat delay", times[1] - times[0], 500);
      check("repeat period", times[2] - times[0], 750);
      check("repeat pattern", pattern, 8'hF8);
      btn_left_n = 1'b1;
      idle_check(15, "repeat release");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
